// File: rtl/axis_uart_if.sv
// axis_uart_if: stream bundle between the AXI-lite-to-stream bridge and the UART endpoint.
//   s_axis_wdata/wvalid/wready : TX word stream, bridge -> UART (only [7:0] is transmitted)
//   m_axis_rdata/rvalid/rready : RX word stream, UART -> bridge, {24'h0, byte}
// master: bridge side. slave: UART side.
interface axis_uart_if;
    logic [31:0] s_axis_wdata;
    logic        s_axis_wvalid;
    logic        s_axis_wready;
    logic [31:0] m_axis_rdata;
    logic        m_axis_rvalid;
    logic        m_axis_rready;

    modport master (
        output s_axis_wdata,
        output s_axis_wvalid,
        input  s_axis_wready,
        input  m_axis_rdata,
        input  m_axis_rvalid,
        output m_axis_rready
    );

    modport slave (
        input  s_axis_wdata,
        input  s_axis_wvalid,
        output s_axis_wready,
        output m_axis_rdata,
        output m_axis_rvalid,
        input  m_axis_rready
    );
endinterface

// File: rtl/axis_uart.sv
// axis_uart: 8N1 serial console endpoint behind the AXI-lite-to-stream bridge.
// Transmits the low byte of each accepted TX word, and returns each received byte as a
// 32-bit word held in a single-entry register with sticky overrun detection.
// Ports:
//   aclk, aresetn  : clock, asynchronous active-low reset
//   axis (slave)   : TX word stream in (wdata/wvalid/wready), RX word stream out
//                    (rdata/rvalid/rready)
//   uart_tx        : serial out, idle high
//   uart_rx        : serial in, asynchronous to aclk
//   rx_frame_err   : one-cycle pulse when a stop bit is sampled low
//   rx_overrun     : sticky, a received byte was dropped because the holding register was full
module axis_uart #(
    parameter int unsigned CLKS_PER_BIT = 16
) (
    input  logic        aclk,
    input  logic        aresetn,
    axis_uart_if.slave  axis,
    output logic        uart_tx,
    input  logic        uart_rx,
    output logic        rx_frame_err,
    output logic        rx_overrun
);

    localparam int unsigned CntW = $clog2(CLKS_PER_BIT);
    localparam logic [CntW-1:0] BitLast  = CntW'(CLKS_PER_BIT - 1);
    localparam logic [CntW-1:0] HalfLast = CntW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CntW-1:0] CntOne   = CntW'(1);

    // ------------------------------------------------------------------
    // TX
    // ------------------------------------------------------------------
    typedef enum logic [1:0] {TxIdle, TxStart, TxData, TxStop} tx_state_e;

    tx_state_e       tx_state_q, tx_state_d;
    logic [CntW-1:0] tx_cnt_q, tx_cnt_d;
    logic [2:0]      tx_idx_q, tx_idx_d;
    logic [7:0]      tx_shift_q, tx_shift_d;
    logic            tx_q, tx_d;

    // Upper word bits are intentionally not transmitted.
    logic unused_wdata;
    assign unused_wdata = ^axis.s_axis_wdata[31:8];

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            tx_state_q <= TxIdle;
            tx_cnt_q   <= '0;
            tx_idx_q   <= '0;
            tx_shift_q <= '0;
            tx_q       <= 1'b1;
        end else begin
            tx_state_q <= tx_state_d;
            tx_cnt_q   <= tx_cnt_d;
            tx_idx_q   <= tx_idx_d;
            tx_shift_q <= tx_shift_d;
            tx_q       <= tx_d;
        end
    end

    // The line level for the next bit is registered on the same edge as the state change, so
    // uart_tx is glitch-free and lines up exactly with the bit-period counter.
    always_comb begin
        tx_state_d = tx_state_q;
        tx_cnt_d   = tx_cnt_q;
        tx_idx_d   = tx_idx_q;
        tx_shift_d = tx_shift_q;
        tx_d       = tx_q;
        unique case (tx_state_q)
            TxIdle: begin
                tx_d = 1'b1;
                if (axis.s_axis_wvalid) begin
                    tx_shift_d = axis.s_axis_wdata[7:0];
                    tx_cnt_d   = BitLast;
                    tx_d       = 1'b0;
                    tx_state_d = TxStart;
                end
            end
            TxStart: begin
                if (tx_cnt_q == '0) begin
                    tx_cnt_d   = BitLast;
                    tx_idx_d   = 3'd0;
                    tx_d       = tx_shift_q[0];
                    tx_state_d = TxData;
                end else begin
                    tx_cnt_d = tx_cnt_q - CntOne;
                end
            end
            TxData: begin
                if (tx_cnt_q == '0) begin
                    tx_cnt_d = BitLast;
                    if (tx_idx_q == 3'd7) begin
                        tx_d       = 1'b1;
                        tx_state_d = TxStop;
                    end else begin
                        tx_idx_d   = tx_idx_q + 3'd1;
                        tx_shift_d = {1'b0, tx_shift_q[7:1]};
                        tx_d       = tx_shift_q[1];
                    end
                end else begin
                    tx_cnt_d = tx_cnt_q - CntOne;
                end
            end
            TxStop: begin
                if (tx_cnt_q == '0) begin
                    tx_state_d = TxIdle;
                end else begin
                    tx_cnt_d = tx_cnt_q - CntOne;
                end
            end
            default: begin
                tx_state_d = TxIdle;
                tx_d       = 1'b1;
            end
        endcase
    end

    assign uart_tx            = tx_q;
    assign axis.s_axis_wready = (tx_state_q == TxIdle);

    // ------------------------------------------------------------------
    // RX
    // ------------------------------------------------------------------
    typedef enum logic [1:0] {RxIdle, RxStart, RxData, RxStop} rx_state_e;

    logic [1:0]      rx_sync_q;
    logic            rx_s;
    rx_state_e       rx_state_q, rx_state_d;
    logic [CntW-1:0] rx_cnt_q, rx_cnt_d;
    logic [2:0]      rx_idx_q, rx_idx_d;
    logic [7:0]      rx_shift_q, rx_shift_d;
    logic [7:0]      rdata_q, rdata_d;
    logic            rvalid_q, rvalid_d;
    logic            overrun_q, overrun_d;
    logic            frame_err_q, frame_err_d;
    logic            rx_deliver;

    // Synchronizer resets to the idle line level so reset never looks like a start bit.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            rx_sync_q <= 2'b11;
        end else begin
            rx_sync_q <= {rx_sync_q[0], uart_rx};
        end
    end

    assign rx_s = rx_sync_q[1];

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            rx_state_q  <= RxIdle;
            rx_cnt_q    <= '0;
            rx_idx_q    <= '0;
            rx_shift_q  <= '0;
            rdata_q     <= '0;
            rvalid_q    <= 1'b0;
            overrun_q   <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            rx_state_q  <= rx_state_d;
            rx_cnt_q    <= rx_cnt_d;
            rx_idx_q    <= rx_idx_d;
            rx_shift_q  <= rx_shift_d;
            rdata_q     <= rdata_d;
            rvalid_q    <= rvalid_d;
            overrun_q   <= overrun_d;
            frame_err_q <= frame_err_d;
        end
    end

    // The first wait is half a bit so every later sample lands mid-bit. The stop sample returns
    // to idle on the same edge so a start bit right after the stop mid-point is not missed.
    always_comb begin
        rx_state_d  = rx_state_q;
        rx_cnt_d    = rx_cnt_q;
        rx_idx_d    = rx_idx_q;
        rx_shift_d  = rx_shift_q;
        frame_err_d = 1'b0;
        rx_deliver  = 1'b0;
        unique case (rx_state_q)
            RxIdle: begin
                if (!rx_s) begin
                    rx_cnt_d   = HalfLast;
                    rx_state_d = RxStart;
                end
            end
            RxStart: begin
                if (rx_cnt_q == '0) begin
                    if (rx_s) begin
                        rx_state_d = RxIdle;
                    end else begin
                        rx_cnt_d   = BitLast;
                        rx_idx_d   = 3'd0;
                        rx_state_d = RxData;
                    end
                end else begin
                    rx_cnt_d = rx_cnt_q - CntOne;
                end
            end
            RxData: begin
                if (rx_cnt_q == '0) begin
                    rx_shift_d = {rx_s, rx_shift_q[7:1]};
                    rx_cnt_d   = BitLast;
                    if (rx_idx_q == 3'd7) begin
                        rx_state_d = RxStop;
                    end else begin
                        rx_idx_d = rx_idx_q + 3'd1;
                    end
                end else begin
                    rx_cnt_d = rx_cnt_q - CntOne;
                end
            end
            RxStop: begin
                if (rx_cnt_q == '0) begin
                    rx_state_d = RxIdle;
                    if (rx_s) begin
                        rx_deliver = 1'b1;
                    end else begin
                        frame_err_d = 1'b1;
                    end
                end else begin
                    rx_cnt_d = rx_cnt_q - CntOne;
                end
            end
            default: rx_state_d = RxIdle;
        endcase
    end

    // Holding register: a byte may land when empty or when the consumer drains it on the same
    // edge; otherwise the old word is kept and the drop is recorded.
    always_comb begin
        rdata_d   = rdata_q;
        rvalid_d  = rvalid_q;
        overrun_d = overrun_q;
        if (rvalid_q && axis.m_axis_rready) begin
            rvalid_d = 1'b0;
        end
        if (rx_deliver) begin
            if (!rvalid_q || axis.m_axis_rready) begin
                rdata_d  = rx_shift_q;
                rvalid_d = 1'b1;
            end else begin
                overrun_d = 1'b1;
            end
        end
    end

    assign axis.m_axis_rdata  = {24'h0, rdata_q};
    assign axis.m_axis_rvalid = rvalid_q;
    assign rx_frame_err       = frame_err_q;
    assign rx_overrun         = overrun_q;

endmodule

// File: tb/tb_axis_uart.sv
// tb_axis_uart: directed checks of axis_uart TX timing, RX sampling, glitch rejection,
// framing error, overrun and reset behaviour.
module tb_axis_uart;
    localparam int unsigned N = 16;

    logic aclk    = 1'b0;
    logic aresetn = 1'b0;
    logic uart_tx;
    logic uart_rx;
    logic rx_frame_err;
    logic rx_overrun;
    logic rx_drv  = 1'b1;
    logic loop_en = 1'b0;

    int total = 0;
    int bad   = 0;

    axis_uart_if bus ();

    assign uart_rx = loop_en ? uart_tx : rx_drv;

    axis_uart #(.CLKS_PER_BIT(N)) dut (
        .aclk         (aclk),
        .aresetn      (aresetn),
        .axis         (bus),
        .uart_tx      (uart_tx),
        .uart_rx      (uart_rx),
        .rx_frame_err (rx_frame_err),
        .rx_overrun   (rx_overrun)
    );

    always #5 aclk = ~aclk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(posedge aclk);
        #1;
    endtask

    // Bit-bangs one frame on uart_rx starting this cycle (cycle 0), then one idle bit.
    // rready is high only in cycle rr_cyc. Counts frame_err-high and rvalid-low cycles.
    task automatic send_rx(input logic [7:0] b, input logic stop_bit, input int rr_cyc,
                           output int nerr, output int nlow);
        logic [9:0] frame;
        logic [3:0] bi;
        frame = {stop_bit, b, 1'b0};
        nerr  = 0;
        nlow  = 0;
        for (int i = 0; i < 11 * int'(N); i++) begin
            bi = 4'(i / int'(N));
            rx_drv = (i < 10 * int'(N)) ? frame[bi] : 1'b1;
            bus.m_axis_rready = (i == rr_cyc);
            if (rx_frame_err) nerr++;
            if (!bus.m_axis_rvalid) nlow++;
            cyc(1);
        end
        bus.m_axis_rready = 1'b0;
    endtask

    logic [7:0]  txb;
    logic [2:0]  b3;
    logic        exp_bit;
    logic        acc;
    int          k;
    int          widx;
    int          nrx;
    int          nerr;
    int          nlow;
    int          nval;
    logic [31:0] got [4];

    initial begin
        bus.s_axis_wdata  = '0;
        bus.s_axis_wvalid = 1'b0;
        bus.m_axis_rready = 1'b0;

        // Reset values while held in reset.
        cyc(2);
        chk("rst_tx",      32'(uart_tx),            32'd1);
        chk("rst_wready",  32'(bus.s_axis_wready),  32'd1);
        chk("rst_rvalid",  32'(bus.m_axis_rvalid),  32'd0);
        chk("rst_rdata",   bus.m_axis_rdata,        32'd0);
        chk("rst_ferr",    32'(rx_frame_err),       32'd0);
        chk("rst_overrun", 32'(rx_overrun),         32'd0);
        #2 aresetn = 1'b1;
        cyc(2);

        // Reset in the middle of a TX frame of 0x00 (line low during data bits).
        bus.s_axis_wdata  = 32'h0000_0000;
        bus.s_axis_wvalid = 1'b1;
        cyc(1);
        bus.s_axis_wvalid = 1'b0;
        cyc(30);
        chk("mid_tx_low", 32'(uart_tx), 32'd0);
        #2 aresetn = 1'b0;
        #1;
        chk("mid_rst_tx",      32'(uart_tx),           32'd1);
        chk("mid_rst_wready",  32'(bus.s_axis_wready), 32'd1);
        chk("mid_rst_rvalid",  32'(bus.m_axis_rvalid), 32'd0);
        chk("mid_rst_overrun", 32'(rx_overrun),        32'd0);
        bus.s_axis_wdata  = 32'h0000_005A;
        bus.s_axis_wvalid = 1'b1;
        #1 aresetn = 1'b1;
        cyc(1);
        chk("post_rst_accept", 32'({bus.s_axis_wready, uart_tx}), 32'b00);
        bus.s_axis_wvalid = 1'b0;
        cyc(10 * N + 2);
        chk("post_rst_idle", 32'(bus.s_axis_wready), 32'd1);

        // TX 0xDEADBEA5 with a second word held valid throughout.
        txb = 8'hA5;
        bus.s_axis_wdata  = 32'hDEAD_BEA5;
        bus.s_axis_wvalid = 1'b1;
        cyc(1);
        bus.s_axis_wdata  = 32'h0000_0012;
        for (int j = 1; j <= 10 * int'(N); j++) begin
            k = (j - 1) / int'(N);
            if (k == 0) begin
                exp_bit = 1'b0;
            end else if (k == 9) begin
                exp_bit = 1'b1;
            end else begin
                b3 = 3'(k - 1);
                exp_bit = txb[b3];
            end
            chk("tx_bit", 32'({bus.s_axis_wready, uart_tx}), 32'({1'b0, exp_bit}));
            cyc(1);
        end
        chk("tx_ready_161", 32'({bus.s_axis_wready, uart_tx}), 32'b11);
        cyc(1);
        chk("tx_second_acc", 32'({bus.s_axis_wready, uart_tx}), 32'b00);
        bus.s_axis_wvalid = 1'b0;
        cyc(10 * N);
        chk("tx_second_done", 32'(bus.s_axis_wready), 32'd1);

        // Loopback 0x3C then 0xC3 back-to-back, rready high.
        loop_en = 1'b1;
        bus.m_axis_rready = 1'b1;
        bus.s_axis_wdata  = 32'h0000_003C;
        bus.s_axis_wvalid = 1'b1;
        widx = 0;
        nrx  = 0;
        nerr = 0;
        for (int c = 0; c < 400; c++) begin
            acc = bus.s_axis_wvalid && bus.s_axis_wready;
            cyc(1);
            if (acc) begin
                widx++;
                if (widx == 1) bus.s_axis_wdata = 32'h0000_00C3;
                else bus.s_axis_wvalid = 1'b0;
            end
            if (bus.m_axis_rvalid) begin
                if (nrx < 4) got[nrx] = bus.m_axis_rdata;
                nrx++;
            end
            if (rx_frame_err) nerr++;
        end
        chk("lb_count",   32'(nrx),        32'd2);
        chk("lb_word0",   got[0],          32'h0000_003C);
        chk("lb_word1",   got[1],          32'h0000_00C3);
        chk("lb_ferr",    32'(nerr),       32'd0);
        chk("lb_overrun", 32'(rx_overrun), 32'd0);
        loop_en = 1'b0;
        bus.m_axis_rready = 1'b0;
        cyc(2);

        // Glitch: 4 cycles low, then a valid 0x55 frame.
        rx_drv = 1'b0;
        cyc(4);
        rx_drv = 1'b1;
        nval = 0;
        nerr = 0;
        for (int c = 0; c < 40; c++) begin
            if (bus.m_axis_rvalid) nval++;
            if (rx_frame_err) nerr++;
            cyc(1);
        end
        chk("glitch_rvalid", 32'(nval), 32'd0);
        chk("glitch_ferr",   32'(nerr), 32'd0);
        send_rx(8'h55, 1'b1, -1, nerr, nlow);
        chk("g55_rvalid", 32'(bus.m_axis_rvalid), 32'd1);
        chk("g55_rdata",  bus.m_axis_rdata,       32'h0000_0055);
        chk("g55_ferr",   32'(nerr),              32'd0);
        bus.m_axis_rready = 1'b1;
        cyc(1);
        bus.m_axis_rready = 1'b0;
        chk("g55_drain", 32'(bus.m_axis_rvalid), 32'd0);

        // Framing error: 0x81 with stop bit low.
        send_rx(8'h81, 1'b0, -1, nerr, nlow);
        chk("ferr_pulse",  32'(nerr),              32'd1);
        chk("ferr_novalid", 32'(nlow),             32'(11 * N));
        chk("ferr_rvalid", 32'(bus.m_axis_rvalid), 32'd0);

        // Overrun with rready low.
        send_rx(8'h11, 1'b1, -1, nerr, nlow);
        chk("ov_first_valid", 32'(bus.m_axis_rvalid), 32'd1);
        chk("ov_first_data",  bus.m_axis_rdata,       32'h0000_0011);
        chk("ov_first_flag",  32'(rx_overrun),        32'd0);
        send_rx(8'h22, 1'b1, -1, nerr, nlow);
        chk("ov_keep_data",  bus.m_axis_rdata,       32'h0000_0011);
        chk("ov_flag",       32'(rx_overrun),        32'd1);
        chk("ov_keep_valid", 32'(bus.m_axis_rvalid), 32'd1);
        bus.m_axis_rready = 1'b1;
        cyc(1);
        bus.m_axis_rready = 1'b0;
        chk("ov_drain_valid", 32'(bus.m_axis_rvalid), 32'd0);
        chk("ov_sticky",      32'(rx_overrun),        32'd1);

        // Reset clears overrun; then drain-and-load on the same edge.
        #2 aresetn = 1'b0;
        #1;
        chk("ov_rst_clear", 32'(rx_overrun), 32'd0);
        #1 aresetn = 1'b1;
        cyc(2);
        send_rx(8'h44, 1'b1, -1, nerr, nlow);
        chk("same_pre_data", bus.m_axis_rdata, 32'h0000_0044);
        // Stop bit is sampled in cycle 2 + N/2 + 9N = 154 of the frame.
        send_rx(8'h33, 1'b1, 154, nerr, nlow);
        chk("same_never_low", 32'(nlow),              32'd0);
        chk("same_valid",     32'(bus.m_axis_rvalid), 32'd1);
        chk("same_data",      bus.m_axis_rdata,       32'h0000_0033);
        chk("same_overrun",   32'(rx_overrun),        32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/axis_uart.md
# axis_uart

Serial console endpoint that sits directly downstream of the AXI-lite-to-stream bridge. It consumes the bridge's 32-bit write stream and transmits the low byte of each word as an 8N1 UART frame. It also receives 8N1 frames and presents each byte as a 32-bit word on the stream the bridge reads from. Each direction has its own bit-timing state machine, and receive has a single-word holding register with overrun detection.

## Interface
- CLKS_PER_BIT, 16, aclk cycles per UART bit; must be even and ≥ 4; counters sized $clog2(CLKS_PER_BIT)
- aclk  in  1  clock; all logic on posedge
- aresetn  in  1  reset, asynchronous, active-low
- s_axis_wdata  in  32  TX word; only [7:0] is sent, [31:8] ignored
- s_axis_wvalid  in  1  TX word valid
- s_axis_wready  out  1  TX ready; high only in TX IDLE
- m_axis_rdata  out  32  RX word, {24'h0, byte}
- m_axis_rvalid  out  1  RX word valid
- m_axis_rready  in  1  RX consumer ready
- uart_tx  out  1  serial out, idle high
- uart_rx  in  1  serial in, asynchronous to aclk
- rx_frame_err  out  1  one-cycle pulse: stop bit sampled 0
- rx_overrun  out  1  sticky: byte dropped because holding register full; cleared only by reset

## Operation
- Reset values: uart_tx=1, s_axis_wready=1, m_axis_rvalid=0, m_axis_rdata=0, rx_frame_err=0, rx_overrun=0, both FSMs IDLE, RX synchronizer flops=1. Reset mid-frame abandons the frame and drives uart_tx=1 immediately.
- TX FSM: IDLE → START → DATA → STOP → IDLE.
  - IDLE: wready=1, uart_tx=1. On wvalid&wready, latch wdata[7:0] and go to START.
  - START: uart_tx=0 for CLKS_PER_BIT cycles.
  - DATA: 8 bits, LSB first, each held CLKS_PER_BIT cycles. A 3-bit index counts 0..7.
  - STOP: uart_tx=1 for CLKS_PER_BIT cycles, then IDLE.
  - wready=0 in START, DATA and STOP.
- RX: uart_rx passes through a 2-flop synchronizer, producing rx_s. The RX FSM has states IDLE → START → DATA → STOP.
  - IDLE: rx_s==0 loads the bit counter with CLKS_PER_BIT/2-1 and enters START.
  - START: at count 0, sample rx_s. If 1 (glitch), return to IDLE with no output. If 0, reload CLKS_PER_BIT-1 and enter DATA.
  - DATA: at each count 0, shift rx_s in LSB first. After 8 samples, enter STOP.
  - STOP: at count 0, sample rx_s and return to IDLE in the same cycle.
    - Sample 1: deliver the byte.
    - Sample 0: pulse rx_frame_err and discard the byte.
- Delivery:
  - If rvalid==0, or rvalid&rready in that same cycle: load rdata={24'h0,byte} and set rvalid=1 next cycle; no overrun.
  - Otherwise, keep the old rdata and set rx_overrun=1.
- rvalid clears on rvalid&rready unless a new byte is loaded in the same cycle.
- TX and RX are fully independent and may run simultaneously.

## Timing
- TX: uart_tx falls on the cycle after the wvalid&wready edge.
- TX bit k is driven for cycles [1+k·N, (k+1)·N], where N=CLKS_PER_BIT, k=0 is the start bit, k=9 is the stop bit.
- TX: wready rises in cycle 10N+1, so the minimum frame spacing is 10N+1 cycles.
- RX: t0 is the first cycle rx_s==0, which is 2 cycles after the uart_rx fall.
  - Start bit is sampled at t0+N/2.
  - Data bit i is sampled at t0+N/2+(i+1)·N.
  - Stop bit is sampled at t0+N/2+9N.
- RX: rvalid (or the rx_frame_err pulse) is asserted in the cycle after the stop sample.
- RX is back in IDLE in that same cycle, so a start bit arriving immediately after the stop mid-point is detected.
- No combinational path from any input to any output except s_axis_wready, which is a function of registered state only.

## Test plan
- Reset: hold aresetn=0 mid-TX-frame.
  - Required: uart_tx=1 asynchronously, plus wready=1, rvalid=0, rx_overrun=0.
  - After release, a new TX word is accepted on the first cycle.
- TX 0xDEADBEA5, N=16.
  - Required: uart_tx is low for 16 cycles, then bits 1,0,1,0,0,1,0,1 at 16 cycles each, then high for 16 cycles.
  - wready stays low for 160 cycles and rises on cycle 161.
  - A second wvalid held throughout is accepted exactly then.
- Loopback uart_tx→uart_rx with 0x3C then 0xC3 back-to-back, rready=1.
  - Required: two rvalid pulses with rdata 0x0000003C, then 0x000000C3.
  - rx_frame_err=0 and rx_overrun=0.
- Glitch: uart_rx low for 4 cycles, then high.
  - Required: no rvalid and no rx_frame_err; RX returns to IDLE.
  - A valid frame of 0x55 sent next is received correctly.
- Framing error: send 0x81 with the stop bit forced to 0.
  - Required: a single-cycle rx_frame_err and no rvalid.
- Overrun, with rready=0:
  - Receive 0x11, then 0x22. Required: rdata stays 0x00000011 and rx_overrun=1.
  - Then pulse rready. Required: rvalid=0 and rx_overrun stays 1.
  - Separately, with rready asserted in the same cycle 0x33 completes: rdata becomes 0x00000033, rvalid stays 1, and there is no overrun.
